// File: rtl/param_shift_engine.sv
// ---------------------------------------------------------------------------
// param_shift_engine
//
// Purpose:
//   Multi-cycle shift/rotate register. A parallel value is loaded while idle.
//   A START command then performs COUNT single-bit shifts, one per clock, in
//   the latched direction and fill mode. BUSY is high while shifting, and DONE
//   pulses for one cycle afterwards. Sits between a bus-side register loader
//   and serial or bit-manipulation consumers.
//
// Parameters:
//   WIDTH  data register width in bits (>= 2)
//   CNT_W  width of the shift count; legal counts are 0 .. 2**CNT_W-1
//
// Ports:
//   i_clk       clock; all state updates on posedge
//   i_rst_n     synchronous active-low reset
//   i_load      load i_data_in into the register (accepted in IDLE only)
//   i_data_in   parallel load value
//   i_start     start a shift operation (accepted in IDLE only; LOAD wins)
//   i_count     number of single-bit shifts to perform
//   i_dir       0 = left (toward MSB), 1 = right (toward LSB)
//   i_mode      00 logical, 01 arithmetic, 10 rotate, 11 serial-fill
//   i_ser_in    fill bit for serial-fill mode, sampled live on each shift
//   o_data_out  shift register contents
//   o_ser_out   last bit shifted out of the register
//   o_busy      high while shifts are in progress
//   o_done      one-cycle completion pulse
// ---------------------------------------------------------------------------
module param_shift_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_ser_out,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOGICAL = 2'b00,
    MODE_ARITH   = 2'b01,
    MODE_ROTATE  = 2'b10,
    MODE_SERIAL  = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // State and registered outputs.
  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic               r_ser;
  logic               r_busy;
  logic               r_done;

  // Operation parameters, captured when START is accepted so that input
  // changes during SHIFT cannot disturb an operation in flight.
  logic [CNT_W-1:0]   r_remaining;
  logic               r_dir;
  mode_t              r_mode;

  state_t             w_next_state;
  logic               w_fill;
  logic               w_out_bit;
  logic [WIDTH-1:0]   w_shifted;

  // -------------------------------------------------------------------------
  // One-bit shift datapath
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb block gets a default at the
  // top, so no path through the case statements can leave it unassigned and
  // infer a latch.
  always_comb begin
    w_fill    = 1'b0;
    w_out_bit = r_dir ? r_data[0] : r_data[WIDTH-1];

    case (r_mode)
      MODE_LOGICAL: w_fill = 1'b0;
      // Arithmetic only differs from logical when shifting right: the
      // sign bit is replicated. A left arithmetic shift fills with zero.
      MODE_ARITH:   w_fill = r_dir ? r_data[WIDTH-1] : 1'b0;
      // Rotate feeds the departing bit straight back in at the other end.
      MODE_ROTATE:  w_fill = w_out_bit;
      MODE_SERIAL:  w_fill = i_ser_in;
      default:      w_fill = 1'b0;
    endcase

    w_shifted = r_dir ? {w_fill, r_data[WIDTH-1:1]}
                      : {r_data[WIDTH-2:0], w_fill};
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;

    case (r_state)
      ST_IDLE: begin
        // LOAD takes priority: a simultaneous START is dropped.
        if (!i_load && i_start) begin
          w_next_state = (i_count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The edge that sees one shift remaining performs the final shift.
        if (r_remaining == CNT_ONE) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data      <= '0;
      r_ser       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_mode      <= MODE_LOGICAL;
    end else begin
      // BUSY and DONE are decoded from the next state and registered, so
      // they line up exactly with the SHIFT and DONE state cycles.
      r_busy <= (w_next_state == ST_SHIFT);
      r_done <= (w_next_state == ST_DONE);

      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_data <= i_data_in;
          end else if (i_start) begin
            r_remaining <= i_count;
            r_dir       <= i_dir;
            r_mode      <= mode_t'(i_mode);
          end
        end
        ST_SHIFT: begin
          r_data      <= w_shifted;
          r_ser       <= w_out_bit;
          r_remaining <= r_remaining - CNT_ONE;
        end
        default: begin
          // DONE: hold all data. LOAD and START are ignored.
        end
      endcase
    end
  end

  assign o_data_out = r_data;
  assign o_ser_out  = r_ser;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_param_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_param_shift_engine
//
// Directed bench for param_shift_engine (WIDTH=32, CNT_W=6).
//
// The expected register value after i shifts is computed in closed form from
// the value present when START was issued, using plain shift and rotate
// arithmetic. The bit leaving on shift i is the MSB (left) or LSB (right) of
// that closed-form value after i-1 shifts.
//
// A negedge compare process checks all four outputs every cycle. Literal
// end-of-operation values pin the model.
// ---------------------------------------------------------------------------
module tb_param_shift_engine;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [W-1:0]  data_in;
  logic          start;
  logic [CW-1:0] count;
  logic          dir;
  logic [1:0]    mode;
  logic          ser_in;
  logic [W-1:0]  data_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  param_shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (load),
    .i_data_in  (data_in),
    .i_start    (start),
    .i_count    (count),
    .i_dir      (dir),
    .i_mode     (mode),
    .i_ser_in   (ser_in),
    .o_data_out (data_out),
    .o_ser_out  (ser_out),
    .o_busy     (busy),
    .o_done     (done)
  );

  int           n_checks    = 0;
  int           n_fail      = 0;
  bit           chk_en      = 1'b0;
  int           busy_cycles = 0;
  int           done_cycles = 0;

  logic [W-1:0] exp_data = '0;
  logic         exp_ser  = 1'b0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Register value after n shifts from orig, with a constant serial fill bit.
  function automatic logic [W-1:0] model(input logic [W-1:0] orig, input int n,
                                         input bit d, input logic [1:0] m,
                                         input bit s);
    logic [W-1:0]        ones;
    logic signed [W-1:0] sv;
    int                  r;
    ones = '1;
    sv   = orig;
    r    = n % W;
    if (!d) begin
      case (m)
        2'b00, 2'b01: return orig << n;
        2'b10:        return (r == 0) ? orig : ((orig << r) | (orig >> (W - r)));
        default:      return (orig << n) | (s ? ~(ones << n) : '0);
      endcase
    end else begin
      case (m)
        2'b00:   return orig >> n;
        2'b01:   return sv >>> n;
        2'b10:   return (r == 0) ? orig : ((orig >> r) | (orig << (W - r)));
        default: return (orig >> n) | (s ? ~(ones >> n) : '0);
      endcase
    end
  endfunction

  function automatic logic leave_bit(input logic [W-1:0] orig, input int i,
                                     input bit d, input logic [1:0] m,
                                     input bit s);
    logic [W-1:0] prev;
    prev = model(orig, i - 1, d, m, s);
    return d ? prev[0] : prev[W-1];
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", data_out, exp_data);
      check("ser_out",  {31'b0, ser_out}, {31'b0, exp_ser});
      check("busy",     {31'b0, busy},    {31'b0, exp_busy});
      check("done",     {31'b0, done},    {31'b0, exp_done});
      if (busy) busy_cycles++;
      if (done) done_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load    = 1'b1;
    data_in = v;
    tick();
    load     = 1'b0;
    exp_data = v;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Run one operation. With poke set, LOAD/START/COUNT/DIR/MODE are
  // scrambled during SHIFT and DONE and must have no effect. A non-zero
  // abort_at pulls reset right after that many shifts.
  task automatic do_op(input int n, input bit d, input logic [1:0] m,
                       input bit s, input bit poke, input int abort_at);
    logic [W-1:0] orig;
    orig   = exp_data;
    count  = CW'(n);
    dir    = d;
    mode   = m;
    ser_in = s;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    busy_cycles = 0;
    done_cycles = 0;
    exp_busy = (n != 0);
    exp_done = (n == 0);
    for (int i = 1; i <= n; i++) begin
      if (poke) begin
        load    = 1'b1;
        data_in = $urandom;
        start   = 1'b1;
        count   = CW'($urandom_range(0, 63));
        dir     = ~d;
        mode    = ~m;
      end
      tick();
      exp_data = model(orig, i, d, m, s);
      exp_ser  = leave_bit(orig, i, d, m, s);
      exp_busy = (i < n);
      exp_done = (i == n);
      if (i == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        exp_data = '0;
        exp_ser  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        return;
      end
    end
    if (poke) begin
      load    = 1'b1;
      data_in = $urandom;
      start   = 1'b1;
    end
    tick();
    load     = 1'b0;
    start    = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b1;
    data_in = 32'hFFFF_FFFF;
    start   = 1'b0;
    count   = '0;
    dir     = 1'b0;
    mode    = 2'b00;
    ser_in  = 1'b0;

    // 1. Reset overrides a simultaneous LOAD.
    tick();
    chk_en = 1'b1;
    check("rst_data", data_out, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    load  = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2. Logical left by 4.
    do_load(32'hA5A5_0F0F);
    do_op(4, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    check("t2_data", data_out, 32'h5A50_F0F0);
    check("t2_ser",  {31'b0, ser_out}, 32'h0);
    check("t2_busy_cycles", busy_cycles, 4);
    check("t2_done_cycles", done_cycles, 1);

    // 3. Arithmetic right by 3.
    do_load(32'h8000_0010);
    do_op(3, 1'b1, 2'b01, 1'b0, 1'b0, 0);
    check("t3_data", data_out, 32'hF000_0002);
    check("t3_ser",  {31'b0, ser_out}, 32'h0);

    // 4. Rotate left by 33 wraps modulo WIDTH.
    do_load(32'h8000_0001);
    do_op(33, 1'b0, 2'b10, 1'b0, 1'b0, 0);
    check("t4_data", data_out, 32'h0000_0003);
    check("t4_ser",  {31'b0, ser_out}, 32'h1);
    check("t4_busy_cycles", busy_cycles, 33);

    // 5. COUNT=0, then LOAD/START noise during SHIFT and DONE.
    do_load(32'h1234_5678);
    do_op(0, 1'b0, 2'b00, 1'b0, 1'b1, 0);
    check("t5_zero_data", data_out, 32'h1234_5678);
    check("t5_zero_busy_cycles", busy_cycles, 0);
    check("t5_zero_done_cycles", done_cycles, 1);
    do_op(8, 1'b0, 2'b00, 1'b0, 1'b1, 0);
    check("t5_poke_data", data_out, 32'h3456_7800);

    // Serial fill left, rotate right, logical right past WIDTH.
    do_load(32'h0000_00F0);
    do_op(4, 1'b0, 2'b11, 1'b1, 1'b0, 0);
    check("ser_left_data", data_out, 32'h0000_0F0F);
    do_load(32'h0000_0001);
    do_op(1, 1'b1, 2'b10, 1'b0, 1'b0, 0);
    check("rot_right_data", data_out, 32'h8000_0000);
    check("rot_right_ser",  {31'b0, ser_out}, 32'h1);
    do_load(32'hFFFF_FFFF);
    do_op(40, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    check("lsr40_data", data_out, 32'h0);

    // 6. Reset after 5 of 20 shifts, then a serial-fill right shift.
    do_load(32'hDEAD_BEEF);
    do_op(20, 1'b0, 2'b00, 1'b0, 1'b0, 5);
    check("t6_abort_data", data_out, 32'h0);
    check("t6_abort_busy", {31'b0, busy}, 32'h0);
    repeat (3) tick();
    check("t6_no_done_cycles", done_cycles, 0);
    do_op(1, 1'b1, 2'b11, 1'b1, 1'b0, 0);
    check("t6_ser_fill_data", data_out, 32'h8000_0000);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
